// File: rtl/subckt_bist_driver.sv
// BIST driver: LFSR patterns into a 7-input subcircuit, MISR compaction of its response.
// Every output is registered; captures trail the driven pattern by LAT cycles.
module subckt_bist_driver #(
  parameter int          N_PAT  = 127,
  parameter int          LAT    = 2,
  parameter logic [6:0]  SEED   = 7'h01,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic        I1470_clk,
  input  logic        I1477_rst,
  input  logic        start,
  input  logic        resp,
  output logic [6:0]  pat,
  output logic        pat_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_lfsr;
  logic [6:0]  r_cnt;
  logic [6:0]  r_pat;
  logic        r_pat_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_misr;
  logic        w_accept;
  logic        w_run_last;
  logic        w_flush_last;
  logic        w_cap;
  logic [15:0] w_misr_nxt;

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  assign w_run_last   = (r_cnt == 7'(N_PAT));
  assign w_flush_last = (r_cnt == 7'(LAT));
  assign w_misr_nxt   = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                      ^ {15'b0, resp};

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN:     if (w_run_last) w_state_nxt = (LAT > 0) ? FLUSH : DONE;
      FLUSH:   if (w_flush_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_cnt counts patterns in RUN, then is reused to count flush cycles
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      r_lfsr      <= SEED;
      r_cnt       <= '0;
      r_pat       <= '0;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_misr      <= '0;
    end else begin
      if (w_cap) r_misr <= w_misr_nxt;
      if (w_accept) begin
        r_lfsr      <= lfsr_step(SEED);
        r_pat       <= SEED;
        r_pat_valid <= 1'b1;
        r_busy      <= 1'b1;
        r_cnt       <= 7'd1;
        r_misr      <= '0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            r_lfsr <= lfsr_step(r_lfsr);
            if (w_run_last) begin
              r_pat       <= '0;
              r_pat_valid <= 1'b0;
              r_cnt       <= 7'd1;
              if (LAT == 0) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_misr_nxt == GOLDEN);
              end
            end else begin
              r_pat <= r_lfsr;
              r_cnt <= r_cnt + 7'd1;
            end
          end
          FLUSH: begin
            if (w_flush_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_pass <= (w_misr_nxt == GOLDEN);
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The final capture always lands on the edge that enters DONE, hence pass uses w_misr_nxt
  generate
    if (LAT > 0) begin : g_dly
      logic [LAT-1:0] r_dly;
      always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= r_pat_valid;
          for (int k = 1; k < LAT; k++) r_dly[k] <= r_dly[k-1];
        end
      end
      assign w_cap = r_dly[LAT-1];
    end else begin : g_nodly
      assign w_cap = r_pat_valid;
    end
  endgenerate

  assign pat       = r_pat;
  assign pat_valid = r_pat_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;

endmodule

// File: tb/tb_subckt_bist_driver.sv
// Bench for subckt_bist_driver: four instances with different N_PAT/LAT, a truth-table
// subcircuit model with latency, and a list-based pattern/signature reference.
module tb_subckt_bist_driver;

  localparam int NI = 4;
  localparam int NP [NI] = '{4, 2, 127, 3};
  localparam int LT [NI] = '{2, 0, 2, 1};

  logic        clk;
  logic        rst_n;
  logic        start_v     [NI];
  logic        resp_v      [NI];
  logic [6:0]  pat_v       [NI];
  logic        pat_valid_v [NI];
  logic        busy_v      [NI];
  logic        done_v      [NI];
  logic        pass_v      [NI];
  logic [15:0] sig_v       [NI];

  logic [127:0] tt    [NI];
  bit           mode  [NI];
  bit           cval  [NI];
  logic [6:0]   hist  [NI][8];

  int checks = 0;
  int errors = 0;

  subckt_bist_driver #(.N_PAT(4), .LAT(2), .SEED(7'h01), .GOLDEN(16'h0000)) u0 (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_v[0]), .resp(resp_v[0]),
    .pat(pat_v[0]), .pat_valid(pat_valid_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .signature(sig_v[0]));
  subckt_bist_driver #(.N_PAT(2), .LAT(0), .SEED(7'h01), .GOLDEN(16'h0000)) u1 (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_v[1]), .resp(resp_v[1]),
    .pat(pat_v[1]), .pat_valid(pat_valid_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .signature(sig_v[1]));
  subckt_bist_driver #(.N_PAT(127), .LAT(2), .SEED(7'h01), .GOLDEN(16'h0000)) u2 (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_v[2]), .resp(resp_v[2]),
    .pat(pat_v[2]), .pat_valid(pat_valid_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .signature(sig_v[2]));
  subckt_bist_driver #(.N_PAT(3), .LAT(1), .SEED(7'h01), .GOLDEN(16'h0000)) u3 (
    .I1470_clk(clk), .I1477_rst(rst_n), .start(start_v[3]), .resp(resp_v[3]),
    .pat(pat_v[3]), .pat_valid(pat_valid_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .signature(sig_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic r);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then play the subcircuit: resp reflects the
  // pattern that was on pat LAT cycles earlier.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = pat_v[i];
      resp_v[i] = mode[i] ? tt[i][hist[i][LT[i]]] : cval[i];
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++)
      chk(tag, {5'b0, pat_v[i], pat_valid_v[i], busy_v[i], done_v[i], pass_v[i], sig_v[i]}, 32'h0);
  endtask

  task automatic do_run(input int i, input bit md, input bit cv, input bit poke);
    int          n, lat, cycles, busy_cnt, distinct, pmis;
    logic [6:0]  got [$];
    logic [6:0]  expp [$];
    logic [6:0]  p;
    logic [15:0] esig;
    bit          seen [128];
    n = NP[i]; lat = LT[i];
    mode[i] = md; cval[i] = cv;
    tt[i] = {$urandom, $urandom, $urandom, $urandom};
    p = 7'h01;
    esig = 16'h0000;
    for (int k = 0; k < n; k++) begin
      expp.push_back(p);
      esig = misr_next(esig, md ? tt[i][p] : cv);
      p = lfsr_next(p);
    end
    start_v[i] = 1'b1;
    cyc();
    start_v[i] = 1'b0;
    chk($sformatf("u%0d_clear_on_start", i), {30'b0, done_v[i], pass_v[i]}, 32'h0);
    cycles = 1; busy_cnt = 0;
    while (!done_v[i] && cycles < n + lat + 20) begin
      if (pat_valid_v[i]) got.push_back(pat_v[i]);
      if (busy_v[i]) busy_cnt++;
      start_v[i] = poke && (cycles == 2 || cycles == n + lat);
      cyc();
      cycles++;
    end
    start_v[i] = 1'b0;
    chk($sformatf("u%0d_done_seen", i), 32'(done_v[i]), 32'h1);
    chk($sformatf("u%0d_done_latency", i), 32'(cycles - 1), 32'(n + lat));
    chk($sformatf("u%0d_busy_cycles", i), 32'(busy_cnt), 32'(n + lat));
    chk($sformatf("u%0d_pat_count", i), 32'(got.size()), 32'(n));
    pmis = 0; distinct = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    for (int k = 0; k < got.size(); k++) begin
      if (k >= n || got[k] !== expp[k]) pmis++;
      if (got[k] != 7'h00 && !seen[got[k]]) begin
        seen[got[k]] = 1'b1;
        distinct++;
      end
    end
    chk($sformatf("u%0d_pat_sequence_mismatches", i), 32'(pmis), 32'h0);
    chk($sformatf("u%0d_distinct_nonzero", i), 32'(distinct), 32'(n));
    chk($sformatf("u%0d_signature", i), 32'(sig_v[i]), 32'(esig));
    chk($sformatf("u%0d_pass", i), 32'(pass_v[i]), 32'(esig == 16'h0000));
    chk($sformatf("u%0d_idle_outputs", i), {23'b0, pat_v[i], pat_valid_v[i], busy_v[i]}, 32'h0);
    for (int k = 0; k < 3; k++) cyc();
    chk($sformatf("u%0d_hold", i), {15'b0, done_v[i], sig_v[i]}, {15'b0, 1'b1, esig});
    if (i == 3 && got.size() >= 3)
      chk("u3_first_three_pats", {11'b0, got[0], got[1], got[2]}, {11'b0, 7'h01, 7'h02, 7'h04});
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; resp_v[i] = 1'b0; mode[i] = 1'b0; cval[i] = 1'b0; tt[i] = '0;
      for (int k = 0; k < 8; k++) hist[i][k] = 7'h00;
    end
    #1;
    chk_reset_outputs("reset_async");
    cyc(); cyc();
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;
    cyc();

    do_run(0, 1'b0, 1'b0, 1'b0);
    chk("u0_const0_sig_pass", {15'b0, pass_v[0], sig_v[0]}, {15'b0, 1'b1, 16'h0000});
    do_run(1, 1'b0, 1'b1, 1'b0);
    chk("u1_const1_sig_pass", {15'b0, pass_v[1], sig_v[1]}, {15'b0, 1'b0, 16'h0003});
    do_run(3, 1'b1, 1'b0, 1'b0);
    do_run(0, 1'b1, 1'b0, 1'b1);
    do_run(1, 1'b1, 1'b0, 1'b1);
    do_run(2, 1'b1, 1'b0, 1'b1);
    do_run(2, 1'b0, 1'b0, 1'b0);
    do_run(3, 1'b1, 1'b0, 1'b1);

    // Abort u0 in its third RUN cycle; u2 sits in DONE with pass=1 so its clear is visible too
    mode[0] = 1'b1;
    start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    cyc(); cyc();
    chk("u0_third_run_cycle", {23'b0, pat_v[0], pat_valid_v[0], busy_v[0]}, {23'b0, 7'h04, 1'b1, 1'b1});
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_midrun");
    cyc();
    rst_n = 1'b1;
    cyc();
    do_run(0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subckt_bist_driver.md
SUBCKT_BIST_DRIVER -- requirements
Module: subckt_bist_driver

Interface
REQ-001 SHALL have parameter N_PAT, default 127, meaning number of patterns applied per run (1..127).
REQ-002 SHALL have parameter LAT, default 2, meaning cycles from pattern drive to a valid subcircuit response (0..7).
REQ-003 SHALL have parameter SEED, default 7'h01, meaning LFSR start value (nonzero).
REQ-004 SHALL have parameter GOLDEN, default 16'h0000, meaning expected final signature.
REQ-005 SHALL have port I1470_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port I1477_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-008 SHALL have port resp, input, 1 bit: subcircuit-under-test output.
REQ-009 SHALL have port pat, output, 7 bits: stimulus to the subcircuit's seven data inputs.
REQ-010 SHALL have port pat_valid, output, 1 bit: pat carries a live pattern this cycle.
REQ-011 SHALL have port busy, output, 1 bit: run in progress.
REQ-012 SHALL have port done, output, 1 bit: run finished; signature and pass are valid.
REQ-013 SHALL have port pass, output, 1 bit: signature equals GOLDEN.
REQ-014 SHALL have port signature, output, 16 bits: MISR contents.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH, DONE; every output is registered.
REQ-016 IDLE or DONE with start=1 SHALL go to RUN next cycle, load LFSR=SEED, clear MISR, pattern counter, done and pass.
REQ-017 start SHALL be ignored in RUN and FLUSH.
REQ-018 RUN SHALL last exactly N_PAT cycles with pat_valid=1; pat = LFSR value; LFSR advances every RUN cycle as next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
REQ-019 RUN's last cycle SHALL go to FLUSH if LAT>0, else to DONE; pat_valid=0 and pat=7'h00 outside RUN.
REQ-020 FLUSH SHALL last exactly LAT cycles, then go to DONE.
REQ-021 Capture enable SHALL be pat_valid delayed by LAT cycles (LAT=0: same cycle); exactly N_PAT captures per run.
REQ-022 On each capture, MISR SHALL update as next = {misr[14:0],1'b0} XOR (misr[15] ? 16'h1021 : 16'h0000) XOR {15'b0, resp}.
REQ-023 Entering DONE SHALL set done=1 and pass=(MISR==GOLDEN); both hold until the next accepted start or reset.
REQ-024 busy SHALL be 1 exactly in RUN and FLUSH.
REQ-025 signature SHALL continuously reflect the MISR register; it is frozen outside captures.
REQ-026 Pattern counter SHALL be 7 bits and never wrap within a run; N_PAT=127 covers the full LFSR period once.

Reset
REQ-027 I1477_rst=0 SHALL immediately force IDLE, LFSR=SEED, MISR=16'h0000, capture delay line cleared, pat=7'h00, pat_valid=0, busy=0, done=0, pass=0, independent of clock.
REQ-028 Reset asserted mid-run SHALL abort the run with no partial done/pass; first accepted start after release begins a fresh run.

Verification
REQ-029 N_PAT=3, start pulse -> pat sequence 7'h01, 7'h02, 7'h04 on three consecutive cycles with pat_valid=1, then pat_valid=0.
REQ-030 N_PAT=4, LAT=2, resp held 0, GOLDEN=16'h0000 -> busy high 6 cycles, done=1, signature=16'h0000, pass=1.
REQ-031 N_PAT=2, LAT=0, resp held 1 -> signature=16'h0003, done=1; with GOLDEN=16'h0000 pass=0.
REQ-032 Reset asserted in third RUN cycle -> all outputs at reset values immediately; new start gives pat=7'h01 first.
REQ-033 start pulses during RUN and FLUSH -> no effect on counts or signature; start in DONE -> done/pass cleared, new run.
REQ-034 N_PAT=127, LAT=2 -> 127 distinct nonzero pat values, 127 captures, done exactly 129 cycles after RUN entry.
